// File: rtl/op_bram_rd_pkg.sv
// Shared types and helpers for the output-BRAM read-out sequencer.
// Holds the FSM state type, the lane width and a constant-width helper.
package op_bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int LANE_W    = 16;
  localparam int DRAINED_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/op_bram_skid_fifo.sv
// First-word-fall-through register FIFO that absorbs BRAM read latency.
// The head entry is always visible on dout while the FIFO is not empty.
module op_bram_skid_fifo
  import op_bram_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             pop;

  assign empty = (count == '0);
  assign pop   = rd_en & ~empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (pop)   rp <= (rp == LAST) ? '0 : rp + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= din;
  end

endmodule

// File: rtl/op_bram_rd_ctrl.sv
// Walks port-B of the output BRAM bank per finished column and
// streams each row out on AXI4-Stream with TLAST and backpressure.
module op_bram_rd_ctrl
  import op_bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LANES  = 32,
  parameter int DATA_WIDTH = 512,
  parameter int RD_LATENCY = 3,
  parameter int SKID_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  col_done,
  input  logic [ADDR_WIDTH:0]   col_len,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  output logic [NUM_LANES-1:0]  bram_enb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  pending,
  output logic                  overrun,
  output logic [DRAINED_W-1:0]  cols_drained
);

  localparam int IF_W  = clog2(RD_LATENCY + 2);
  localparam int CNT_W = clog2(SKID_DEPTH + 1);
  localparam int SUM_W = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;
  localparam logic [ADDR_WIDTH:0] ONE = 1;

  if (SKID_DEPTH < RD_LATENCY + 2) begin : g_depth_chk
    $error("SKID_DEPTH must be at least RD_LATENCY+2");
  end
  if (DATA_WIDTH != NUM_LANES * LANE_W) begin : g_width_chk
    $error("DATA_WIDTH must equal NUM_LANES*16");
  end

  state_t                state;
  logic [ADDR_WIDTH:0]   rd_addr;
  logic [ADDR_WIDTH:0]   rd_len;
  logic [ADDR_WIDTH:0]   pend_len;
  logic [ADDR_WIDTH:0]   start_len;
  logic                  en_q;
  logic                  last_q;
  logic [RD_LATENCY-1:0] vpipe;
  logic [RD_LATENCY-1:0] lpipe;
  logic [IF_W-1:0]       inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  issue_ok;
  logic                  drain_done;
  logic                  req;
  logic                  take_pend;
  logic                  start;
  logic                  pop;
  logic                  issue_end;

  // enb stage plus every pipe stage holds a read not yet in the FIFO
  always_comb begin
    inflight = IF_W'(en_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + IF_W'(vpipe[i]);
    end
  end

  assign issue_ok = (SUM_W'(inflight) + SUM_W'(fifo_count))
                    < SUM_W'(SKID_DEPTH);
  assign drain_done = (state == DRAIN) && (inflight == '0)
                      && fifo_empty;
  assign req       = col_done && (col_len != '0);
  assign take_pend = pending && ((state == IDLE) || drain_done);
  assign start     = take_pend || ((state == IDLE) && req);
  assign start_len = take_pend ? pend_len : col_len;
  assign issue_end = (rd_addr == rd_len - ONE);
  assign pop       = m_axis_tvalid & m_axis_tready;

  assign bram_enb      = {NUM_LANES{en_q}};
  assign busy          = (state != IDLE);
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_dout[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_dout[DATA_WIDTH] & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rd_addr      <= '0;
      rd_len       <= '0;
      pend_len     <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      cols_drained <= '0;
      en_q         <= 1'b0;
      last_q       <= 1'b0;
      bram_addrb   <= '0;
      vpipe        <= '0;
      lpipe        <= '0;
    end else begin
      en_q   <= 1'b0;
      last_q <= 1'b0;
      vpipe  <= (vpipe << 1) | RD_LATENCY'(en_q);
      lpipe  <= (lpipe << 1) | RD_LATENCY'(en_q & last_q);
      if (drain_done) cols_drained <= cols_drained + 1'b1;

      // a new column issues row 0 on the same edge it is accepted
      if (start) begin
        en_q       <= 1'b1;
        last_q     <= (start_len == ONE);
        bram_addrb <= '0;
        rd_addr    <= ONE;
        rd_len     <= start_len;
        state      <= (start_len == ONE) ? DRAIN : ISSUE;
      end else if (drain_done) begin
        state <= IDLE;
      end else if ((state == ISSUE) && issue_ok) begin
        en_q       <= 1'b1;
        last_q     <= issue_end;
        bram_addrb <= rd_addr[ADDR_WIDTH-1:0];
        rd_addr    <= rd_addr + ONE;
        if (issue_end) state <= DRAIN;
      end

      if (req && ((state != IDLE) || take_pend)) begin
        if (pending && !take_pend) begin
          overrun <= 1'b1;
        end else begin
          pending  <= 1'b1;
          pend_len <= col_len;
        end
      end else if (take_pend) begin
        pending <= 1'b0;
      end
    end
  end

  op_bram_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(SKID_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .wr_en(vpipe[RD_LATENCY-1]),
    .din  ({lpipe[RD_LATENCY-1], bram_doutb}),
    .rd_en(pop),
    .dout (fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_op_bram_rd_ctrl.sv
// Scoreboard bench for op_bram_rd_ctrl with a 3-cycle BRAM model.
// Lane b of row a holds {a[10:0], b[4:0]}.
module tb_op_bram_rd_ctrl;

  localparam int AW = 11;
  localparam int NL = 32;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          col_done = 1'b0;
  logic [AW:0]   col_len = '0;
  logic [AW-1:0] bram_addrb;
  logic [NL-1:0] bram_enb;
  logic [DW-1:0] bram_doutb = '0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          tlast;
  logic          busy;
  logic          pending;
  logic          overrun;
  logic [15:0]   cols_drained;

  int tests = 0;
  int fails = 0;
  int mode  = 0;

  always #5 clk = ~clk;

  op_bram_rd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .col_done     (col_done),
    .col_len      (col_len),
    .bram_addrb   (bram_addrb),
    .bram_enb     (bram_enb),
    .bram_doutb   (bram_doutb),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .busy         (busy),
    .pending      (pending),
    .overrun      (overrun),
    .cols_drained (cols_drained)
  );

  function automatic logic [DW-1:0] gen(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < NL; b++) r[16*b +: 16] = {a, 5'(b)};
    return r;
  endfunction

  always @(posedge clk) begin
    d1         <= gen(bram_addrb);
    d2         <= d1;
    bram_doutb <= d2;
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      tready = (mode == 0) ? 1'b1 : ((ph == 0) || (ph == 3));
      ph = (ph + 1) % 4;
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [DW:0]   sb[$];
  int            cyc = 0;
  int            issued = 0;
  int            popped = 0;
  int            col_beats = 0;
  int            col_first = 0;
  int            col_span = 0;
  int            col_seen = 0;
  int            last_cyc = 0;
  int            last_gap = -1;
  int            tlast_cnt = 0;
  bit            after_last = 0;
  bit            prev_stall = 0;
  bit            seen_full = 0;
  logic [DW:0]   held = '0;
  logic [AW-1:0] last_addr = '0;

  task automatic push_col(input int len);
    for (int a = 0; a < len; a++) begin
      sb.push_back({a == len - 1, gen(AW'(a))});
    end
  endtask

  initial begin
    logic [DW:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        sb.delete();
        issued     = 0;
        popped     = 0;
        col_beats  = 0;
        prev_stall = 0;
        after_last = 0;
      end else begin
        if (prev_stall) begin
          check("axi_hold", (tvalid && ({tlast, tdata} == held)), 1);
        end
        if (bram_enb != '0) begin
          issued++;
          last_addr = bram_addrb;
          check("enb_all", (bram_enb == '1), 1);
          check("credit", (issued - popped <= 8), 1);
          if (issued - popped == 8) seen_full = 1;
        end
        if (tvalid && tready) begin
          popped++;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL extra_beat: got row %0h expected none",
                     tdata[15:0]);
          end else begin
            exp = sb.pop_front();
            if ({tlast, tdata} !== exp) begin
              fails++;
              $display("FAIL beat: got last=%0b lane0=%0h expected last=%0b lane0=%0h",
                       tlast, tdata[15:0], exp[DW], exp[15:0]);
            end
          end
          if (after_last) last_gap = cyc - last_cyc - 1;
          after_last = 0;
          if (col_beats == 0) col_first = cyc;
          col_beats++;
          if (tlast) begin
            tlast_cnt++;
            col_seen   = col_beats;
            col_span   = cyc - col_first;
            col_beats  = 0;
            last_cyc   = cyc;
            after_last = 1;
          end
        end
        prev_stall = tvalid && !tready;
        held       = {tlast, tdata};
      end
    end
  end

  task automatic pulse(input int len);
    @(posedge clk);
    #1;
    col_done = 1'b1;
    col_len  = (AW + 1)'(len);
    @(posedge clk);
    #1;
    col_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy && !pending && !tvalid && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  initial begin
    int exp_cols;
    int t0;
    int i0;
    bit ok;
    bit busy_seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_enb", bram_enb, 0);
    check("rst_addr", bram_addrb, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cols", cols_drained, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single short column, cycle-exact
    push_col(4);
    pulse(4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("t1_enb", (bram_enb != '0), (c <= 4));
      if (c <= 4) check("t1_addr", bram_addrb, c - 1);
      check("t1_tvalid", tvalid, (c >= 5 && c <= 8));
      check("t1_tlast", tlast, (c == 8));
      if (c == 10) begin
        check("t1_busy", busy, 0);
        check("t1_cols", cols_drained, 1);
      end
    end
    exp_cols = 1;
    wait_idle(50);

    // backpressure 1,0,0,1
    seen_full = 0;
    mode = 1;
    push_col(16);
    pulse(16);
    wait_idle(400);
    mode = 0;
    exp_cols++;
    check("t2_cols", cols_drained, exp_cols);
    check("t2_credit_full", seen_full, 1);

    // pending and overrun
    t0 = tlast_cnt;
    push_col(6);
    push_col(8);
    pulse(6);
    pulse(8);
    pulse(5);
    @(negedge clk);
    check("t3_pending", pending, 1);
    check("t3_overrun", overrun, 1);
    wait_idle(300);
    exp_cols += 2;
    check("t3_tlasts", tlast_cnt - t0, 2);
    check("t3_cols", cols_drained, exp_cols);
    check("t3_gap", last_gap, 5);
    check("t3_overrun_sticky", overrun, 1);

    // full-depth column
    push_col(2048);
    pulse(2048);
    wait_idle(2600);
    exp_cols++;
    check("t4_beats", col_seen, 2048);
    check("t4_span", col_span, 2047);
    check("t4_last_addr", last_addr, 'h7FF);
    check("t4_cols", cols_drained, exp_cols);

    // reset mid-column
    push_col(20);
    pulse(20);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (col_beats >= 5) begin
        ok = 1;
        break;
      end
    end
    check("t5_reach5", ok, 1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_tvalid", tvalid, 0);
    check("t5_busy", busy, 0);
    check("t5_cols", cols_drained, 0);
    check("t5_overrun", overrun, 0);
    check("t5_pending", pending, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_col(2);
    pulse(2);
    wait_idle(50);
    check("t5_beats", col_seen, 2);
    check("t5_cols_after", cols_drained, 1);

    // zero-length request is ignored
    i0 = issued;
    exp_cols = 1;
    busy_seen = 0;
    pulse(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("t6_enb", issued - i0, 0);
    check("t6_busy", busy_seen, 0);
    check("t6_cols", cols_drained, exp_cols);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
